// File: rtl/irq_ctrl.sv
// irq_ctrl -- four-source interrupt controller with a single CPU request line.
//
// Registers (word addresses):
//   BASE_ADDR   ICTRL  [3:0] en, [7:4] edge (1=rising edge, 0=level),
//                      [11:8] pend (read-only), other bits read 0
//   BASE_ADDR+2 ICLAIM read = claim (16'h8000|id while requesting),
//                      write = end-of-interrupt while in service
//
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous reset, active low
//   src       interrupt sources (0=timer, 1=UART RX, 2=UART TX, 3=GPIO)
//   mem_addr  CPU bus address
//   rd_mem    CPU read strobe (address phase)
//   wr_mem    CPU write strobe
//   byt       byte access flag
//   wr_data   write data; odd-address bytes arrive on [15:8]
//   rd_data   read data, registered one cycle after the address phase
//   irq       interrupt request, high exactly while in REQ
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | nothing requested; waiting for an enabled pending source
// REQ     | irq asserted; waiting for the CPU to claim
// SERVICE | claimed; waiting for an ICLAIM write (EOI), no nesting

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module irq_ctrl #(
  parameter int unsigned BASE_ADDR = 'h00C
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             src,
  input  logic [`ADDR_WIDTH-1:0] mem_addr,
  input  logic                   rd_mem,
  input  logic                   wr_mem,
  input  logic                   byt,
  input  logic [15:0]            wr_data,
  output logic [15:0]            rd_data,
  output logic                   irq
);

  localparam int AW = `ADDR_WIDTH;
  localparam logic [AW-1:0] CTRL_ADDR  = AW'(BASE_ADDR);
  localparam logic [AW-1:0] CLAIM_ADDR = AW'(BASE_ADDR + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] en;
  logic [3:0] edge_mode;
  logic [3:0] latch;
  logic [3:0] src_d;

  logic       sel_ctrl;
  logic       sel_claim;
  logic       ctrl_wr;
  logic       claim_wr;
  logic       claim_rd;
  logic       claim_ok;
  logic [3:0] rise;
  logic [3:0] pend;
  logic [3:0] active;
  logic [1:0] id;
  logic [3:0] latch_clr;
  logic [3:0] latch_keep;
  logic [3:0] latch_nxt;

  // Odd-lane write bytes only ever target the odd ICTRL byte, which is ignored.
  logic unused_wr_hi;
  assign unused_wr_hi = &{1'b0, wr_data[15:8]};

  assign sel_ctrl  = (mem_addr[AW-1:1] == CTRL_ADDR[AW-1:1]);
  assign sel_claim = (mem_addr[AW-1:1] == CLAIM_ADDR[AW-1:1]);

  assign ctrl_wr  = wr_mem & sel_ctrl & (~byt | ~mem_addr[0]);
  assign claim_wr = wr_mem & sel_claim;
  assign claim_rd = rd_mem & sel_claim;

  assign rise   = edge_mode & src & ~src_d;
  assign pend   = (edge_mode & latch) | (~edge_mode & src);
  assign active = pend & en;

  // Lowest index wins.
  always_comb begin
    id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (active[i]) id = 2'(i);
    end
  end

  // A claim only counts while something is still requesting; if the request
  // vanished in the same cycle the FSM falls back to IDLE instead.
  assign claim_ok = claim_rd & (state == REQ) & (active != 4'd0);

  // Clear on claim, then a same-cycle new edge re-sets, then clearing the
  // edge mode bit discards whatever is latched.
  always_comb begin
    latch_clr  = claim_ok ? ((4'b0001 << id) & edge_mode) : 4'b0000;
    latch_keep = ctrl_wr ? wr_data[7:4] : 4'b1111;
    latch_nxt  = ((latch & ~latch_clr) | rise) & latch_keep;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en        <= 4'd0;
      edge_mode <= 4'd0;
      latch     <= 4'd0;
      src_d     <= 4'd0;
    end else begin
      src_d <= src;
      latch <= latch_nxt;
      if (ctrl_wr) begin
        en        <= wr_data[3:0];
        edge_mode <= wr_data[7:4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      irq   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (active != 4'd0) begin
            state <= REQ;
            irq   <= 1'b1;
          end
        end
        REQ: begin
          if (active == 4'd0) begin
            state <= IDLE;
            irq   <= 1'b0;
          end else if (claim_rd) begin
            state <= SERVICE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (claim_wr) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= 16'h0000;
    end else if (rd_mem & sel_ctrl) begin
      rd_data <= {4'h0, pend, edge_mode, en};
    end else if (claim_ok) begin
      rd_data <= 16'h8000 | {14'h0000, id};
    end else begin
      rd_data <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module tb_irq_ctrl;

  localparam int AW = `ADDR_WIDTH;
  localparam logic [AW-1:0] BASE  = AW'('h00C);
  localparam logic [AW-1:0] CLAIM = BASE + AW'(2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    src = 4'd0;
  logic [AW-1:0] mem_addr = '0;
  logic          rd_mem = 1'b0;
  logic          wr_mem = 1'b0;
  logic          byt = 1'b0;
  logic [15:0]   wr_data = 16'h0000;
  logic [15:0]   rd_data;
  logic          irq;

  irq_ctrl #(.BASE_ADDR('h00C)) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .mem_addr (mem_addr),
    .rd_mem   (rd_mem),
    .wr_mem   (wr_mem),
    .byt      (byt),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-source bookkeeping: enable, edge mode, captured edge, previous level.
  // mode: 0 = nothing requested, 1 = requesting, 2 = in service.
  bit [3:0]    m_en = 0, m_edge = 0, m_latch = 0, m_prev = 0;
  int          m_mode = 0;
  bit          m_irq = 0;
  bit          rd_pend = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    bit [3:0] pend, act, nx;
    int       id;
    bit       hit_ctrl, hit_claim, ctrl_write;
    if (!rst) begin
      m_en = 0; m_edge = 0; m_latch = 0; m_prev = 0;
      m_mode = 0; m_irq = 0; rd_pend = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < 4; i++) pend[i] = m_edge[i] ? m_latch[i] : src[i];
      act = pend & m_en;
      id = -1;
      for (int i = 0; i < 4; i++) if (act[i] && id < 0) id = i;
      hit_ctrl   = (mem_addr[AW-1:1] == BASE[AW-1:1]);
      hit_claim  = (mem_addr[AW-1:1] == CLAIM[AW-1:1]);
      ctrl_write = wr_mem && hit_ctrl && (!byt || !mem_addr[0]);

      rd_pend = rd_mem;
      if (rd_mem) begin
        if (hit_ctrl) exp_q.push_back({4'h0, pend, m_edge, m_en});
        else if (hit_claim && m_mode == 1 && id >= 0) exp_q.push_back(16'h8000 + 16'(id));
        else exp_q.push_back(16'h0000);
      end

      for (int i = 0; i < 4; i++) begin
        nx[i] = m_latch[i];
        if (m_mode == 1 && rd_mem && hit_claim && id == i && m_edge[i]) nx[i] = 0;
        if (m_edge[i] && src[i] && !m_prev[i]) nx[i] = 1;
        if (ctrl_write && !wr_data[4+i]) nx[i] = 0;
      end
      m_latch = nx;

      case (m_mode)
        0: if (id >= 0) m_mode = 1;
        1: if (id < 0) m_mode = 0;
           else if (rd_mem && hit_claim) m_mode = 2;
        default: if (wr_mem && hit_claim) m_mode = 0;
      endcase
      m_irq = (m_mode == 1);

      if (ctrl_write) begin
        m_en   = wr_data[3:0];
        m_edge = wr_data[7:4];
      end
      m_prev = src;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("irq_vs_model", {15'b0, irq}, {15'b0, m_irq});
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_scoreboard: got %h expected <empty queue> at %0t", rd_data, $time);
      end else begin
        chk("rd_data_vs_model", rd_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(logic [AW-1:0] a, logic [15:0] d, logic b);
    mem_addr = a; wr_data = d; byt = b; wr_mem = 1'b1;
    tick();
    wr_mem = 1'b0; byt = 1'b0;
  endtask

  task automatic bus_read(logic [AW-1:0] a, logic b, output logic [15:0] d);
    mem_addr = a; byt = b; rd_mem = 1'b1;
    tick();
    rd_mem = 1'b0; byt = 1'b0;
    d = rd_data;
  endtask

  task automatic wait_irq(logic lvl, int max, string name);
    int k = 0;
    while (irq !== lvl && k < max) begin
      tick();
      k++;
    end
    chk(name, {15'b0, irq}, {15'b0, lvl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] d;
    rst = 1'b0;
    tick(); tick();
    chk("reset_rd_data", rd_data, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    rst = 1'b1;
    tick();
    bus_read(BASE, 1'b0, d);
    chk("reset_ictrl", d, 16'h0000);

    // timer, level
    bus_write(BASE, 16'h0001, 1'b0);
    src = 4'b0001;
    wait_irq(1'b1, 2, "lvl_irq_rise");
    bus_read(CLAIM, 1'b0, d);
    chk("lvl_claim", d, 16'h8000);
    chk("lvl_irq_after_claim", {15'b0, irq}, 16'h0000);
    src = 4'b0000;
    tick();
    bus_write(CLAIM, 16'h0000, 1'b0);
    tick(); tick();
    chk("lvl_irq_after_eoi", {15'b0, irq}, 16'h0000);

    // sources 1 and 2, edge mode, simultaneous pulse
    bus_write(BASE, 16'h00F6, 1'b0);
    src = 4'b0110;
    tick();
    src = 4'b0000;
    wait_irq(1'b1, 3, "edge_irq_first");
    bus_read(CLAIM, 1'b0, d);
    chk("edge_claim_first", d, 16'h8001);
    bus_write(CLAIM, 16'h0000, 1'b0);
    wait_irq(1'b1, 3, "edge_irq_second");
    bus_read(CLAIM, 1'b0, d);
    chk("edge_claim_second", d, 16'h8002);
    bus_write(CLAIM, 16'h0000, 1'b0);
    bus_read(BASE, 1'b0, d);
    chk("edge_pend_clear", {12'h000, d[11:8]}, 16'h0000);

    // raise a source while in service
    bus_write(BASE, 16'h0009, 1'b0);
    src = 4'b1000;
    wait_irq(1'b1, 2, "svc_irq_src3");
    bus_read(CLAIM, 1'b0, d);
    chk("svc_claim_src3", d, 16'h8003);
    src = 4'b0001;
    tick(); tick();
    chk("svc_irq_blocked", {15'b0, irq}, 16'h0000);
    bus_write(CLAIM, 16'h0000, 1'b0);
    chk("svc_irq_idle_cycle", {15'b0, irq}, 16'h0000);
    tick();
    chk("svc_irq_reassert", {15'b0, irq}, 16'h0001);

    // ICLAIM write in REQ is ignored; claim in IDLE returns zero
    bus_write(CLAIM, 16'h0000, 1'b0);
    chk("req_write_ignored", {15'b0, irq}, 16'h0001);
    bus_read(CLAIM, 1'b0, d);
    chk("req_claim_src0", d, 16'h8000);
    src = 4'b0000;
    bus_write(CLAIM, 16'h0000, 1'b0);
    bus_read(CLAIM, 1'b0, d);
    chk("idle_claim_zero", d, 16'h0000);
    tick();
    chk("idle_stays_idle", {15'b0, irq}, 16'h0000);

    // byte lanes
    bus_write(BASE, 16'h00A5, 1'b0);
    bus_write(BASE + AW'(1), 16'h5500, 1'b1);
    bus_read(BASE, 1'b0, d);
    chk("odd_byte_ignored", {8'h00, d[7:0]}, 16'h00A5);
    bus_write(BASE, 16'h0003, 1'b1);
    bus_read(BASE + AW'(1), 1'b1, d);
    chk("even_byte_en", {12'h000, d[3:0]}, 16'h0003);
    chk("even_byte_low", {8'h00, d[7:0]}, 16'h0003);

    // reset while in service
    bus_write(BASE, 16'h0001, 1'b0);
    src = 4'b0001;
    wait_irq(1'b1, 2, "rst_irq_rise");
    bus_read(CLAIM, 1'b0, d);
    chk("rst_claim", d, 16'h8000);
    #4;
    rst = 1'b0;
    src = 4'b0000;
    #1;
    chk("rst_async_irq", {15'b0, irq}, 16'h0000);
    chk("rst_async_rd_data", rd_data, 16'h0000);
    tick(); tick();
    rst = 1'b1;
    tick();
    bus_read(BASE, 1'b0, d);
    chk("rst_ictrl_zero", d, 16'h0000);
    src = 4'b0001;
    tick(); tick();
    chk("rst_needs_enable", {15'b0, irq}, 16'h0000);
    bus_write(BASE, 16'h0001, 1'b0);
    wait_irq(1'b1, 2, "rst_irq_after_enable");
    bus_read(CLAIM, 1'b0, d);
    bus_write(CLAIM, 16'h0000, 1'b0);

    // randomized traffic, checked by the model and monitor
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) src = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       bus_write(BASE + AW'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        1, 2:    bus_read(CLAIM, 1'b0, d);
        3:       bus_write(CLAIM, 16'($urandom), 1'b0);
        4:       bus_read(BASE + AW'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
        5:       bus_read(AW'($urandom), 1'b0, d);
        default: tick();
      endcase
    end

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 'h00C, word address of ICTRL; ICLAIM sits at BASE_ADDR+2.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have port: src  input  4  interrupt sources: 0=timer, 1=UART RX, 2=UART TX, 3=GPIO.
REQ-005 SHALL have port: mem_addr  input  `ADDR_WIDTH  CPU bus address.
REQ-006 SHALL have port: rd_mem  input  1  CPU read strobe, address phase.
REQ-007 SHALL have port: wr_mem  input  1  CPU write strobe.
REQ-008 SHALL have port: byt  input  1  byte access flag.
REQ-009 SHALL have port: wr_data  input  16  write data; odd-address bytes arrive on [15:8].
REQ-010 SHALL have port: rd_data  output  16  registered read data.
REQ-011 SHALL have port: irq  output  1  interrupt request to CPU, registered.

Function
REQ-012 SHALL decode sel_ctrl = mem_addr[`ADDR_WIDTH-1:1]==BASE_ADDR>>1 and sel_claim = mem_addr[`ADDR_WIDTH-1:1]==(BASE_ADDR+2)>>1.
REQ-013 SHALL hold ICTRL: en[3:0] in bits 3:0, edge[3:0] in bits 7:4 (1=rising edge, 0=level), read-only pend[3:0] in bits 11:8, other bits read 0.
REQ-014 SHALL update en/edge on a word write to ICTRL, or on a byte write to the even ICTRL address; a byte write to the odd address SHALL be ignored.
REQ-015 SHALL register src into src_d every cycle and set the edge-latch bit i when edge[i] & src[i] & ~src_d[i].
REQ-016 SHALL define pend[i] = edge[i] ? latch[i] : src[i], and active = pend & en.
REQ-017 SHALL resolve priority with the lowest index winning; id = index of the lowest set bit of active.
REQ-018 SHALL run an FSM with states IDLE, REQ and SERVICE.
REQ-019 In IDLE, SHALL go to REQ when active != 0.
REQ-020 In REQ, SHALL return to IDLE if active becomes 0 before a claim.
REQ-021 In REQ, SHALL go to SERVICE on a claim read.
REQ-022 In SERVICE, SHALL go to IDLE on any write to ICLAIM; no nesting.
REQ-023 SHALL drive irq = 1 exactly while the FSM state is REQ; irq reaches 1 one cycle after the source event registers.
REQ-024 Claim read SHALL be rd_mem & sel_claim in the address cycle. In REQ it SHALL return 16'h8000|id. In IDLE or SERVICE it SHALL return 16'h0000 and leave all state unchanged.
REQ-025 A claim SHALL clear latch[id] when edge[id]=1; if a new edge on the same source arrives in the same cycle, set SHALL win.
REQ-026 SHALL register rd_data on the cycle after the address phase. A non-selected read SHALL return 16'h0000. Byte reads SHALL return the full word; the CPU selects the byte lane.
REQ-027 Clearing en[i] SHALL NOT clear latch[i]; the latch fires when the source is re-enabled.
REQ-028 A write to ICLAIM outside SERVICE SHALL be ignored.
REQ-029 SHALL treat clear-to-0 of edge[i] as discarding latch[i].

Reset
REQ-030 While rst=0, SHALL force state=IDLE, en=0, edge=0, latch=0, src_d=0, irq=0 and rd_data=0, independent of clk.
REQ-031 On rst assertion mid-SERVICE, SHALL abandon the service without EOI. After release, the first irq SHALL require a fresh source event plus enable.

Verification
REQ-032 Bench SHALL cover: ICTRL=16'h0001 (timer, level), src[0]=1 -> irq=1 within 2 cycles; claim read returns 16'h8000; irq=0 next cycle; src[0] low then ICLAIM write -> IDLE, irq stays 0.
REQ-033 Bench SHALL cover: ICTRL=16'h00F6 (srcs 1,2 enabled, edge); pulse src[1] and src[2] in the same cycle -> claim returns 16'h8001; after EOI, irq reasserts and claim returns 16'h8002; after the second EOI, pend=0.
REQ-034 Bench SHALL cover: in SERVICE, raise src[0] (enabled) -> irq stays 0; EOI -> irq=1 the cycle after IDLE is re-entered.
REQ-035 Bench SHALL cover: claim read in IDLE returns 16'h0000 and the state stays IDLE; ICLAIM write in REQ leaves irq=1.
REQ-036 Bench SHALL cover: byte write 8'h55 to odd address BASE_ADDR+1 -> ICTRL[7:0] unchanged; byte write 16'h0003 to BASE_ADDR -> en=4'b0011.
REQ-037 Bench SHALL cover: rst low while in SERVICE -> irq=0, rd_data=0, ICTRL reads 16'h0000 after release.
